shell_pool: RTL



---
 rtl/shell_pool.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/shell_pool.sv
// Projectile pool for one tank: allocates the lowest free slot on fire, enforces a
// re-fire cooldown and steps in-flight shells. Optional: SHELL_POOL_EDGE_RETIRE_EN.
module shell_pool #(
   parameter int NUM_SHELLS = 5,
   parameter int POS_W      = 6,
   parameter int X_MAX      = 39,
   parameter int Y_MAX      = 29,
   parameter int STEP_DIV   = 400000,
   parameter int COOLDOWN   = 0
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             fire,
   input  logic                                             fire_en,
   input  logic [1:0]                                       direction,
   input  logic [POS_W-1:0]                                 tank_x,
   input  logic [POS_W-1:0]                                 tank_y,
   input  logic [NUM_SHELLS-1:0]                            vanish,
   output logic [NUM_SHELLS*POS_W-1:0]                      shell_x,
   output logic [NUM_SHELLS*POS_W-1:0]                      shell_y,
   output logic [NUM_SHELLS-1:0]                            shell_active,
   output logic                                             fire_ack,
   output logic [((NUM_SHELLS > 1) ? $clog2(NUM_SHELLS) : 1)-1:0] fire_idx
);

   localparam int IDX_W  = (NUM_SHELLS > 1) ? $clog2(NUM_SHELLS) : 1;
   localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int COOL_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
   localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN);

   typedef enum logic {
      FREE = 1'b0,
      FLY  = 1'b1
   } slot_state_t;

   slot_state_t        state    [NUM_SHELLS];
   logic [STEP_W-1:0]  step_cnt [NUM_SHELLS];
   logic [1:0]         dir_q    [NUM_SHELLS];
   logic [POS_W-1:0]   pos_x    [NUM_SHELLS];
   logic [POS_W-1:0]   pos_y    [NUM_SHELLS];
   logic [POS_W-1:0]   step_x   [NUM_SHELLS];
   logic [POS_W-1:0]   step_y   [NUM_SHELLS];
   logic [COOL_W-1:0]  cool_cnt;
   logic               any_free;
   logic [IDX_W-1:0]   free_idx;
   logic               accept;

   // Lowest-index free slot, judged on the state at the start of the cycle
   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int k = NUM_SHELLS - 1; k >= 0; k--) begin
         if (state[k] == FREE) begin
            any_free = 1'b1;
            free_idx = IDX_W'(k);
         end
      end
   end

   assign accept = fire & fire_en & (cool_cnt == '0) & any_free;

   always_comb begin
      for (int k = 0; k < NUM_SHELLS; k++) begin
         step_x[k] = pos_x[k];
         step_y[k] = pos_y[k];
         case (dir_q[k])
            2'd0:    step_y[k] = pos_y[k] - POS_W'(1);
            2'd1:    step_y[k] = pos_y[k] + POS_W'(1);
            2'd2:    step_x[k] = pos_x[k] - POS_W'(1);
            default: step_x[k] = pos_x[k] + POS_W'(1);
         endcase
      end
   end

`ifdef SHELL_POOL_EDGE_RETIRE_EN
   logic [NUM_SHELLS-1:0] off_grid;

   always_comb begin
      for (int k = 0; k < NUM_SHELLS; k++) begin
         case (dir_q[k])
            2'd0:    off_grid[k] = (pos_y[k] == '0);
            2'd1:    off_grid[k] = (pos_y[k] == POS_W'(Y_MAX));
            2'd2:    off_grid[k] = (pos_x[k] == '0);
            default: off_grid[k] = (pos_x[k] == POS_W'(X_MAX));
         endcase
      end
   end
`endif

   // Per-slot FREE/FLY machine; vanish outranks a step landing on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_SHELLS; k++) begin
            state[k]    <= FREE;
            step_cnt[k] <= '0;
            dir_q[k]    <= 2'd0;
            pos_x[k]    <= '0;
            pos_y[k]    <= '0;
         end
         cool_cnt <= '0;
         fire_ack <= 1'b0;
         fire_idx <= '0;
      end else begin
         fire_ack <= accept;
         if (accept) begin
            fire_idx <= free_idx;
            cool_cnt <= COOL_LOAD;
         end else if (cool_cnt != '0) begin
            cool_cnt <= cool_cnt - 1'b1;
         end

         for (int k = 0; k < NUM_SHELLS; k++) begin
            case (state[k])
               FREE: begin
                  step_cnt[k] <= '0;
                  pos_x[k]    <= tank_x;
                  pos_y[k]    <= tank_y;
                  if (accept && (free_idx == IDX_W'(k))) begin
                     state[k] <= FLY;
                     dir_q[k] <= direction;
                  end
               end
               FLY: begin
                  if (vanish[k]) begin
                     state[k]    <= FREE;
                     step_cnt[k] <= '0;
                  end else if (step_cnt[k] == STEP_LAST) begin
                     step_cnt[k] <= '0;
`ifdef SHELL_POOL_EDGE_RETIRE_EN
                     if (off_grid[k]) begin
                        state[k] <= FREE;
                     end else begin
                        pos_x[k] <= step_x[k];
                        pos_y[k] <= step_y[k];
                     end
`else
                     pos_x[k] <= step_x[k];
                     pos_y[k] <= step_y[k];
`endif
                  end else begin
                     step_cnt[k] <= step_cnt[k] + 1'b1;
                  end
               end
               default: state[k] <= FREE;
            endcase
         end
      end
   end

   for (genvar k = 0; k < NUM_SHELLS; k++) begin : g_out
      assign shell_x[k*POS_W +: POS_W] = pos_x[k];
      assign shell_y[k*POS_W +: POS_W] = pos_y[k];
      assign shell_active[k]           = (state[k] == FLY);
   end

endmodule
